// File: rtl/alu_acc_pkg.sv
// alu_acc_pkg: shared types for the accumulator ALU block.
//   alu_op_e : 4-bit operation codes driven from the F switches
//   flags_t  : registered status flags {Cout, OV, Zf, Nf}
//   state_e  : control FSM states
//   hex7     : hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}
package alu_acc_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,  OP_OR   = 4'd1,  OP_XOR  = 4'd2,  OP_NOR  = 4'd3,
    OP_ADD  = 4'd4,  OP_SUB  = 4'd5,  OP_SLT  = 4'd6,  OP_SLTU = 4'd7,
    OP_SHL  = 4'd8,  OP_SHR  = 4'd9,  OP_SAR  = 4'd10, OP_PASS = 4'd11,
    OP_R12  = 4'd12, OP_R13  = 4'd13, OP_R14  = 4'd14, OP_R15  = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic cout;
    logic ov;
    logic zf;
    logic nf;
  } flags_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_acc_fpga_alu_n.sv
// alu_n: combinational N-bit ALU.
//   a, b  : operands (a = accumulator snapshot, b = switch operand)
//   op    : operation code
//   y     : N-bit result
//   flags : {Cout, OV} valid for ADD/SUB only, Zf/Nf derived from y
module alu_n
  import alu_acc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  alu_op_e      op,
  output logic [N-1:0] y,
  output flags_t       flags
);

  localparam int SW = $clog2(N);

  logic [SW-1:0] sh;
  logic [N:0]    sum;
  logic [N:0]    dif;

  assign sh  = b[SW-1:0];
  assign sum = {1'b0, a} + {1'b0, b};
  // subtraction as a + ~b + 1 so the carry means "no borrow"
  assign dif = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};

  always_comb begin
    y          = '0;
    flags.cout = 1'b0;
    flags.ov   = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_ADD: begin
        y          = sum[N-1:0];
        flags.cout = sum[N];
        flags.ov   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        y          = dif[N-1:0];
        flags.cout = dif[N];
        flags.ov   = (a[N-1] != b[N-1]) && (dif[N-1] != a[N-1]);
      end
      OP_SLT:  y = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: y = {{(N-1){1'b0}}, (a < b)};
      OP_SHL:  y = a << sh;
      OP_SHR:  y = a >> sh;
      OP_SAR:  y = $signed(a) >>> sh;
      OP_PASS: y = b;
      default: y = '0;
    endcase
    flags.zf = (y == '0);
    flags.nf = y[N-1];
  end

endmodule

// File: rtl/alu_acc_fpga_btn_pulse.sv
// btn_pulse: two-flop synchroniser plus rising-edge detector for a raw button.
//   clk, reset : system clock, synchronous active-high reset
//   btn        : raw asynchronous button level
//   pulse      : one-cycle pulse per press, 3 cycles after the first sampled high
module btn_pulse (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic s1_q, s2_q, s3_q, pulse_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      // registered so downstream logic sees a glitch-free single-cycle strobe
      pulse_q <= s2_q & ~s3_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/alu_acc_fpga_display.sv
// multi_digit_display: hex value to active-low seven-segment digits.
//   value : 4*NUM_DIGITS bits, digit 0 is the least significant nibble
//   seg   : 7 bits per digit, digit 0 in seg[6:0]
module multi_digit_display
  import alu_acc_pkg::*;
#(
  parameter int NUM_DIGITS = 2
) (
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic [7*NUM_DIGITS-1:0] seg
);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign seg[7*gi +: 7] = hex7(value[4*gi +: 4]);
  end

endmodule

// File: rtl/alu_acc_fpga.sv
// alu_acc_fpga: button-driven accumulator ALU for direct pin-level use.
//   clk, reset         : system clock, synchronous active-high reset
//   A                  : operand switches (inverted internally when A_ACTIVE_LOW)
//   F                  : op code switches
//   load_btn, exec_btn : raw buttons; load copies A into acc, exec runs F on acc,A
//   acc                : accumulator
//   Cout, OV, Zf, Nf   : registered flags
//   busy               : high in EXEC and WRITE
//   ops                : wrapping count of completed exec operations
//   seg                : active-low seven-segment view of acc
module alu_acc_fpga
  import alu_acc_pkg::*;
#(
  parameter int N            = 8,
  parameter int NUM_DIGITS   = (N + 3) / 4,
  parameter bit A_ACTIVE_LOW = 1'b1,
  parameter int CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N-1:0]            A,
  input  logic [3:0]              F,
  input  logic                    load_btn,
  input  logic                    exec_btn,
  output logic [N-1:0]            acc,
  output logic                    Cout,
  output logic                    OV,
  output logic                    Zf,
  output logic                    Nf,
  output logic                    busy,
  output logic [CNT_W-1:0]        ops,
  output logic [7*NUM_DIGITS-1:0] seg
);

  logic             load_p, exec_p;
  logic [N-1:0]     ai;
  state_e           state_q, state_d;
  logic [N-1:0]     acc_q, opa_q, opb_q, res_q, alu_y;
  alu_op_e          op_q;
  flags_t           flags_q, rflags_q, alu_flags;
  logic [CNT_W-1:0] ops_q;

  btn_pulse u_load (.clk(clk), .reset(reset), .btn(load_btn), .pulse(load_p));
  btn_pulse u_exec (.clk(clk), .reset(reset), .btn(exec_btn), .pulse(exec_p));

  assign ai = A_ACTIVE_LOW ? ~A : A;

  alu_n #(.N(N)) u_alu (
    .a(opa_q), .b(opb_q), .op(op_q), .y(alu_y), .flags(alu_flags)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next state: a simultaneous load suppresses the exec pulse
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (exec_p && !load_p) state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  // datapath: pulses outside IDLE are simply ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      flags_q  <= '0;
      ops_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= OP_AND;
      res_q    <= '0;
      rflags_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_p) begin
            acc_q   <= ai;
            flags_q <= '0;
          end else if (exec_p) begin
            opa_q <= acc_q;
            opb_q <= ai;
            op_q  <= alu_op_e'(F);
          end
        end
        ST_EXEC: begin
          res_q    <= alu_y;
          rflags_q <= alu_flags;
        end
        ST_WRITE: begin
          acc_q   <= res_q;
          flags_q <= rflags_q;
          ops_q   <= ops_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign acc  = acc_q;
  assign Cout = flags_q.cout;
  assign OV   = flags_q.ov;
  assign Zf   = flags_q.zf;
  assign Nf   = flags_q.nf;
  assign ops  = ops_q;

  logic [4*NUM_DIGITS-1:0] disp_val;
  assign disp_val = {{(4*NUM_DIGITS-N){1'b0}}, acc_q};

  multi_digit_display #(.NUM_DIGITS(NUM_DIGITS)) u_disp (
    .value(disp_val), .seg(seg)
  );

endmodule

// File: tb/tb_alu_acc_fpga.sv
module tb_alu_acc_fpga;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  A;
  logic [3:0]  F;
  logic        load_btn, exec_btn;
  logic [7:0]  acc;
  logic        Cout, OV, Zf, Nf, busy;
  logic [7:0]  ops;
  logic [13:0] seg;

  int total = 0;
  int bad   = 0;
  int bcnt;

  alu_acc_fpga #(.N(8), .NUM_DIGITS(2), .A_ACTIVE_LOW(1'b0), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .A(A), .F(F),
    .load_btn(load_btn), .exec_btn(exec_btn),
    .acc(acc), .Cout(Cout), .OV(OV), .Zf(Zf), .Nf(Nf),
    .busy(busy), .ops(ops), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-12s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Raise the selected buttons for 'hold' cycles, then let the pipeline
  // settle; returns how many sampled cycles busy was high.
  task automatic press(input logic ld, input logic ex, input int hold, output int nbusy);
    nbusy = 0;
    @(negedge clk);
    load_btn = ld;
    exec_btn = ex;
    for (int i = 0; i < hold + 10; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (i == hold - 1) begin
        load_btn = 1'b0;
        exec_btn = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; A = '0; F = '0; load_btn = 1'b0; exec_btn = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // reset / idle state
    check("rst_acc",   acc, 8'h00);
    check("rst_flags", {Cout, OV, Zf, Nf}, 4'b0000);
    check("rst_ops",   ops, 8'd0);
    check("rst_busy",  busy, 1'b0);
    check("rst_seg",   seg, 14'h2040);

    // load 0x7F, ADD 0x01 -> 0x80 signed overflow
    A = 8'h7F; press(1'b1, 1'b0, 1, bcnt);
    check("load7f", acc, 8'h7F);
    A = 8'h01; F = 4'd4; press(1'b0, 1'b1, 1, bcnt);
    check("add_acc",   acc, 8'h80);
    check("add_flags", {Cout, OV, Zf, Nf}, 4'b0101);
    check("add_ops",   ops, 8'd1);
    check("add_busy",  bcnt, 32'd2);
    check("add_seg",   seg, 14'h0040);

    // load 5, SUB 5 -> zero with no borrow; then SLT 0 < 1
    A = 8'h05; press(1'b1, 1'b0, 1, bcnt);
    F = 4'd5; press(1'b0, 1'b1, 1, bcnt);
    check("sub_acc",   acc, 8'h00);
    check("sub_flags", {Cout, OV, Zf, Nf}, 4'b1010);
    A = 8'h01; F = 4'd6; press(1'b0, 1'b1, 1, bcnt);
    check("slt_acc",   acc, 8'h01);
    check("slt_flags", {Cout, OV, Zf, Nf}, 4'b0000);

    // held exec button: exactly one XOR
    A = 8'h0F; press(1'b1, 1'b0, 1, bcnt);
    A = 8'hFF; F = 4'd2; press(1'b0, 1'b1, 20, bcnt);
    check("hold_acc",   acc, 8'hF0);
    check("hold_ops",   ops, 8'd4);
    check("hold_busy",  bcnt, 32'd2);
    check("hold_flags", {Cout, OV, Zf, Nf}, 4'b0001);

    // load and exec pulse together: load wins
    A = 8'h33; F = 4'd4; press(1'b1, 1'b1, 1, bcnt);
    check("both_acc",   acc, 8'h33);
    check("both_flags", {Cout, OV, Zf, Nf}, 4'b0000);
    check("both_ops",   ops, 8'd4);
    check("both_busy",  bcnt, 32'd0);
    check("both_seg",   seg, {7'h30, 7'h30});

    // second exec pulse lands in WRITE and must be dropped
    A = 8'hFF; F = 4'd2;
    @(negedge clk); exec_btn = 1'b1;
    @(negedge clk); exec_btn = 1'b0;
    @(negedge clk); exec_btn = 1'b1;
    @(negedge clk); exec_btn = 1'b0;
    repeat (10) @(negedge clk);
    check("bsy_acc", acc, 8'hCC);
    check("bsy_ops", ops, 8'd5);

    // reset while in EXEC
    A = 8'h01; F = 4'd4;
    @(negedge clk); exec_btn = 1'b1;
    @(negedge clk); exec_btn = 1'b0;
    begin
      int w = 0;
      while (!busy && w < 12) begin @(negedge clk); w++; end
      check("exec_seen", busy, 1'b1);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rexec_acc",  acc, 8'h00);
    check("rexec_ops",  ops, 8'd0);
    check("rexec_busy", busy, 1'b0);
    repeat (6) @(negedge clk);
    check("rexec_acc2", acc, 8'h00);
    check("rexec_ops2", ops, 8'd0);

    // ops counter wraps after 256 execs
    F = 4'd11; A = 8'h5A;
    for (int k = 0; k < 255; k++) press(1'b0, 1'b1, 1, bcnt);
    check("ops_255", ops, 8'd255);
    check("pass_acc", acc, 8'h5A);
    press(1'b0, 1'b1, 1, bcnt);
    check("ops_wrap", ops, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
